// File: rtl/alarm_controller.sv
// alarm_controller: anti-theft FSM that arms, triggers and sounds the siren.
// Ports: clock/reset, ignition and door inputs, reprogram port, timer handshake, siren/LED/state outputs.
module alarm_controller #(
   parameter logic [3:0] T_ARM_DEFAULT    = 4'd6,
   parameter logic [3:0] T_DRIVER_DEFAULT = 4'd8,
   parameter logic [3:0] T_PASS_DEFAULT   = 4'd15,
   parameter logic [3:0] T_ALARM_DEFAULT  = 4'd10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ignition,
   input  logic       door_driver,
   input  logic       door_pass,
   input  logic       reprogram,
   input  logic [1:0] time_param_sel,
   input  logic [3:0] time_value,
   input  logic       expired,
   input  logic       one_hz_enable,
   output logic       start_timer,
   output logic [3:0] value,
   output logic       siren_en,
   output logic       status_led,
   output logic [2:0] state_out
);

   localparam logic [2:0] ARMED           = 3'd0;
   localparam logic [2:0] TRIGGERED       = 3'd1;
   localparam logic [2:0] SIREN           = 3'd2;
   localparam logic [2:0] DISARMED        = 3'd3;
   localparam logic [2:0] WAIT_DOOR_CLOSE = 3'd4;
   localparam logic [2:0] WAIT_ARM        = 3'd5;

   localparam logic [1:0] SEL_ARM    = 2'd0;
   localparam logic [1:0] SEL_DRIVER = 2'd1;
   localparam logic [1:0] SEL_PASS   = 2'd2;
   localparam logic [1:0] SEL_ALARM  = 2'd3;

   logic [3:0] t_arm;
   logic [3:0] t_driver;
   logic [3:0] t_pass;
   logic [3:0] t_alarm;

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic       launch;
   logic [1:0] launch_sel;
   logic [3:0] launch_val;
   logic       led_nxt;
   logic       exp_valid;
   logic       any_door;

   // The timer still reports its idle expired=1 while the start pulse is
   // out, so expiry only counts once the pulse has been seen by the timer.
   assign exp_valid = expired & ~start_timer;
   assign any_door  = door_driver | door_pass;
   assign state_out = state;

   // Programmable interval registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         t_arm    <= T_ARM_DEFAULT;
         t_driver <= T_DRIVER_DEFAULT;
         t_pass   <= T_PASS_DEFAULT;
         t_alarm  <= T_ALARM_DEFAULT;
      end else if (reprogram) begin
         unique case (time_param_sel)
            SEL_ARM:    t_arm    <= time_value;
            SEL_DRIVER: t_driver <= time_value;
            SEL_PASS:   t_pass   <= time_value;
            SEL_ALARM:  t_alarm  <= time_value;
            default:    t_arm    <= time_value;
         endcase
      end
   end

   // Next-state and interval launch selection
   always_comb begin
      state_nxt  = state;
      launch     = 1'b0;
      launch_sel = SEL_ARM;
      if (reprogram) begin
         state_nxt = ARMED;
      end else begin
         unique case (state)
            ARMED: begin
               if (ignition) begin
                  state_nxt = DISARMED;
               end else if (door_driver) begin
                  state_nxt  = TRIGGERED;
                  launch     = 1'b1;
                  launch_sel = SEL_DRIVER;
               end else if (door_pass) begin
                  state_nxt  = TRIGGERED;
                  launch     = 1'b1;
                  launch_sel = SEL_PASS;
               end
            end
            TRIGGERED: begin
               if (ignition) begin
                  state_nxt = DISARMED;
               end else if (exp_valid) begin
                  state_nxt  = SIREN;
                  launch     = 1'b1;
                  launch_sel = SEL_ALARM;
               end
            end
            SIREN: begin
               if (ignition) begin
                  state_nxt = DISARMED;
               end else if (exp_valid) begin
                  if (any_door) begin
                     launch     = 1'b1;
                     launch_sel = SEL_ALARM;
                  end else begin
                     state_nxt = ARMED;
                  end
               end
            end
            DISARMED: begin
               if (!ignition && door_driver) begin
                  state_nxt = WAIT_DOOR_CLOSE;
               end
            end
            WAIT_DOOR_CLOSE: begin
               if (ignition) begin
                  state_nxt = DISARMED;
               end else if (!any_door) begin
                  state_nxt  = WAIT_ARM;
                  launch     = 1'b1;
                  launch_sel = SEL_ARM;
               end
            end
            WAIT_ARM: begin
               if (ignition) begin
                  state_nxt = DISARMED;
               end else if (any_door) begin
                  state_nxt = WAIT_DOOR_CLOSE;
               end else if (exp_valid) begin
                  state_nxt = ARMED;
               end
            end
            default: begin
               state_nxt = ARMED;
            end
         endcase
      end
   end

   // Interval value read straight from the parameter registers
   always_comb begin
      launch_val = t_arm;
      unique case (launch_sel)
         SEL_ARM:    launch_val = t_arm;
         SEL_DRIVER: launch_val = t_driver;
         SEL_PASS:   launch_val = t_pass;
         SEL_ALARM:  launch_val = t_alarm;
         default:    launch_val = t_arm;
      endcase
   end

   // LED follows the destination state; TRIGGERED blinks on the 1 Hz tick
   // but always lights on entry.
   always_comb begin
      led_nxt = 1'b1;
      unique case (state_nxt)
         ARMED:     led_nxt = 1'b1;
         SIREN:     led_nxt = 1'b1;
         TRIGGERED: begin
            if (state == TRIGGERED) begin
               led_nxt = status_led ^ one_hz_enable;
            end else begin
               led_nxt = 1'b1;
            end
         end
         default:   led_nxt = 1'b0;
      endcase
   end

   // Registered state and outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ARMED;
         start_timer <= 1'b0;
         value       <= 4'd0;
         siren_en    <= 1'b0;
         status_led  <= 1'b1;
      end else begin
         state       <= state_nxt;
         start_timer <= launch;
         if (launch) begin
            value <= launch_val;
         end
         siren_en    <= (state_nxt == SIREN);
         status_led  <= led_nxt;
      end
   end

endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed bench for alarm_controller with a
// behavioural reference model checked every cycle plus literal spot checks.
module tb_alarm_controller;

   logic       clock;
   logic       reset;
   logic       ignition;
   logic       door_driver;
   logic       door_pass;
   logic       reprogram;
   logic [1:0] time_param_sel;
   logic [3:0] time_value;
   logic       expired;
   logic       one_hz_enable;
   logic       start_timer;
   logic [3:0] value;
   logic       siren_en;
   logic       status_led;
   logic [2:0] state_out;

   int n_cmp = 0;
   int n_bad = 0;

   alarm_controller dut (
      .clock          (clock),
      .reset          (reset),
      .ignition       (ignition),
      .door_driver    (door_driver),
      .door_pass      (door_pass),
      .reprogram      (reprogram),
      .time_param_sel (time_param_sel),
      .time_value     (time_value),
      .expired        (expired),
      .one_hz_enable  (one_hz_enable),
      .start_timer    (start_timer),
      .value          (value),
      .siren_en       (siren_en),
      .status_led     (status_led),
      .state_out      (state_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: state numbers are the published debug encodings
   // (0 ARMED, 1 TRIGGERED, 2 SIREN, 3 DISARMED, 4 WAIT_DOOR_CLOSE, 5 WAIT_ARM).
   int         m_state;
   bit         m_start;
   int         m_value;
   bit         m_siren;
   bit         m_led;
   int         m_par [4];
   int         m_nxt;
   int         m_launch;
   bit         m_honour;
   bit         m_doors;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_state = 0;
         m_start = 0;
         m_value = 0;
         m_siren = 0;
         m_led   = 1;
         m_par   = '{6, 8, 15, 10};
      end else begin
         m_honour = expired && !m_start;
         m_doors  = door_driver || door_pass;
         m_nxt    = m_state;
         m_launch = -1;
         if (reprogram) begin
            m_par[time_param_sel] = time_value;
            m_nxt = 0;
         end else if (m_state == 0) begin
            if (ignition) m_nxt = 3;
            else if (door_driver) begin m_nxt = 1; m_launch = 1; end
            else if (door_pass) begin m_nxt = 1; m_launch = 2; end
         end else if (m_state == 1) begin
            if (ignition) m_nxt = 3;
            else if (m_honour) begin m_nxt = 2; m_launch = 3; end
         end else if (m_state == 2) begin
            if (ignition) m_nxt = 3;
            else if (m_honour && m_doors) m_launch = 3;
            else if (m_honour) m_nxt = 0;
         end else if (m_state == 3) begin
            if (!ignition && door_driver) m_nxt = 4;
         end else if (m_state == 4) begin
            if (ignition) m_nxt = 3;
            else if (!m_doors) begin m_nxt = 5; m_launch = 0; end
         end else if (m_state == 5) begin
            if (ignition) m_nxt = 3;
            else if (m_doors) m_nxt = 4;
            else if (m_honour) m_nxt = 0;
         end
         m_start = (m_launch >= 0);
         if (m_start) m_value = m_par[m_launch];
         if (m_nxt == 1 && m_state == 1) m_led = m_led ^ one_hz_enable;
         else m_led = (m_nxt == 0 || m_nxt == 1 || m_nxt == 2);
         m_siren = (m_nxt == 2);
         m_state = m_nxt;
      end
   end

   always @(negedge clock) begin
      chk("m_state_out", int'(state_out), m_state);
      chk("m_start_timer", int'(start_timer), int'(m_start));
      chk("m_value", int'(value), m_value);
      chk("m_siren_en", int'(siren_en), int'(m_siren));
      chk("m_status_led", int'(status_led), int'(m_led));
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      reset          = 1;
      ignition       = 0;
      door_driver    = 0;
      door_pass      = 0;
      reprogram      = 0;
      time_param_sel = 0;
      time_value     = 0;
      expired        = 0;
      one_hz_enable  = 0;
      tick(2);
      chk("rst_state", int'(state_out), 0);
      chk("rst_start", int'(start_timer), 0);
      chk("rst_value", int'(value), 0);
      chk("rst_siren", int'(siren_en), 0);
      chk("rst_led", int'(status_led), 1);
      reset = 0;
      tick(1);

      door_driver = 1;
      tick(1);
      chk("drv_state", int'(state_out), 1);
      chk("drv_start", int'(start_timer), 1);
      chk("drv_value", int'(value), 8);
      door_driver = 0;
      for (int i = 0; i < 80; i++) begin
         one_hz_enable = (i % 10 == 9);
         tick(1);
      end
      one_hz_enable = 0;
      expired = 1;
      tick(1);
      chk("exp_state", int'(state_out), 2);
      chk("exp_start", int'(start_timer), 1);
      chk("exp_value", int'(value), 10);
      chk("exp_siren", int'(siren_en), 1);
      expired = 0;

      tick(1);
      door_pass = 1;
      expired   = 1;
      tick(1);
      chk("restart_state", int'(state_out), 2);
      chk("restart_start", int'(start_timer), 1);
      chk("restart_value", int'(value), 10);
      door_pass = 0;
      expired   = 0;
      tick(2);
      expired = 1;
      tick(1);
      chk("rearm_state", int'(state_out), 0);
      chk("rearm_siren", int'(siren_en), 0);
      chk("rearm_led", int'(status_led), 1);

      door_pass = 1;
      tick(1);
      chk("pass_state", int'(state_out), 1);
      chk("pass_value", int'(value), 15);
      door_pass = 0;
      tick(1);
      chk("guard_state", int'(state_out), 1);
      chk("guard_start", int'(start_timer), 0);
      tick(1);
      chk("guard_take", int'(state_out), 2);
      chk("guard_value", int'(value), 10);
      expired  = 0;
      ignition = 1;
      tick(1);
      chk("siren_off_state", int'(state_out), 3);
      chk("siren_off_siren", int'(siren_en), 0);
      chk("siren_off_led", int'(status_led), 0);

      ignition    = 0;
      door_driver = 1;
      tick(1);
      chk("wdc_state", int'(state_out), 4);
      door_driver = 0;
      tick(1);
      chk("warm_state", int'(state_out), 5);
      chk("warm_value", int'(value), 6);
      tick(2);
      door_driver = 1;
      tick(1);
      chk("reopen_state", int'(state_out), 4);
      door_driver = 0;
      tick(1);
      chk("warm2_start", int'(start_timer), 1);
      chk("warm2_value", int'(value), 6);
      expired = 1;
      tick(1);
      chk("warm_guard", int'(state_out), 5);
      tick(1);
      chk("armed_again", int'(state_out), 0);
      expired = 0;

      door_driver = 1;
      tick(1);
      chk("trig2_value", int'(value), 8);
      door_driver   = 0;
      one_hz_enable = 1;
      tick(1);
      one_hz_enable = 0;
      chk("blink_led", int'(status_led), 0);
      tick(2);
      ignition = 1;
      tick(1);
      chk("dis_state", int'(state_out), 3);
      chk("dis_siren", int'(siren_en), 0);
      chk("dis_led", int'(status_led), 0);
      expired = 1;
      tick(5);
      expired = 0;
      chk("dis_quiet", int'(start_timer), 0);
      chk("dis_stays", int'(state_out), 3);

      ignition       = 0;
      reprogram      = 1;
      time_param_sel = 2;
      time_value     = 3;
      tick(1);
      reprogram = 0;
      chk("rp_state", int'(state_out), 0);
      chk("rp_start", int'(start_timer), 0);
      chk("rp_led", int'(status_led), 1);
      door_pass = 1;
      tick(1);
      chk("rp_value", int'(value), 3);
      door_pass = 0;
      expired   = 1;
      tick(2);
      chk("rp_siren_state", int'(state_out), 2);
      chk("rp_siren_on", int'(siren_en), 1);
      expired = 0;
      tick(1);
      #3 reset = 1;
      #1;
      chk("arst_siren", int'(siren_en), 0);
      chk("arst_led", int'(status_led), 1);
      chk("arst_state", int'(state_out), 0);
      tick(1);
      reset = 0;
      tick(1);
      door_pass = 1;
      tick(1);
      chk("pass_default", int'(value), 15);
      door_pass = 0;

      reprogram      = 1;
      time_param_sel = 0;
      time_value     = 2;
      door_driver    = 1;
      tick(1);
      reprogram = 0;
      chk("rp_over_state", int'(state_out), 0);
      chk("rp_over_start", int'(start_timer), 0);
      door_pass = 1;
      tick(1);
      chk("prio_value", int'(value), 8);
      chk("prio_state", int'(state_out), 1);
      door_driver = 0;
      door_pass   = 0;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Anti-theft control FSM for the car-alarm system.
- Initiator side of the countdown-timer interface: selects an interval, issues a one-cycle start_timer pulse with a 4-bit value, then consumes expired and one_hz_enable from the timer.
- Holds four programmable time parameters and drives the siren enable and the status LED.

Parameters:
- T_ARM_DEFAULT, 4'd6, arming delay in seconds after the driver leaves.
- T_DRIVER_DEFAULT, 4'd8, entry delay in seconds for the driver door.
- T_PASS_DEFAULT, 4'd15, entry delay in seconds for the passenger door.
- T_ALARM_DEFAULT, 4'd10, siren-on interval in seconds.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high.
- ignition  in  1  1 = key on.
- door_driver  in  1  1 = driver door open.
- door_pass  in  1  1 = passenger door open.
- reprogram  in  1  1-cycle strobe; writes time_value into the parameter selected by time_param_sel.
- time_param_sel  in  2  0 = ARM, 1 = DRIVER, 2 = PASS, 3 = ALARM.
- time_value  in  4  new parameter value in seconds.
- expired  in  1  from timer; 1 when the count is zero.
- one_hz_enable  in  1  from timer; 1-cycle tick once per second while counting.
- start_timer  out  1  registered 1-cycle pulse to the timer.
- value  out  4  registered interval, valid during the start_timer cycle.
- siren_en  out  1  registered siren enable.
- status_led  out  1  registered status indicator.
- state_out  out  3  current state encoding, for debug.

Behaviour:
- Reset (async, any time, including mid-countdown):
  - state = ARMED; start_timer = 0; value = 0; siren_en = 0; status_led = 1.
  - Parameters revert to their defaults.
  - A timer that is still running is ignored from then on.
- State encodings: ARMED = 0, TRIGGERED = 1, SIREN = 2, DISARMED = 3, WAIT_DOOR_CLOSE = 4, WAIT_ARM = 5.
- Start handshake:
  - On every transition that launches an interval, start_timer = 1 for exactly one cycle, with value = the selected parameter in that same cycle.
  - Otherwise start_timer = 0 and value holds its last value.
- Expiry guard:
  - expired is ignored at the clock edge where start_timer = 1, because the timer still shows its idle expired = 1 there.
  - expired is honoured from the following edge onward.
  - A parameter of 0 therefore expires 2 edges after the start edge.
- ARMED (status_led = 1, siren_en = 0):
  - ignition = 1 → DISARMED.
  - Else door_driver = 1 → TRIGGERED, start with T_DRIVER.
  - Else door_pass = 1 → TRIGGERED, start with T_PASS.
  - If both doors open in the same cycle, driver takes priority.
- TRIGGERED:
  - status_led toggles on each one_hz_enable; it is set to 1 on entry.
  - ignition = 1 → DISARMED.
  - Else a valid expired → SIREN, start with T_ALARM.
- SIREN (siren_en = 1, status_led = 1):
  - ignition = 1 → DISARMED, siren_en = 0 in the next cycle.
  - Valid expired with either door open → stay in SIREN and restart T_ALARM.
  - Valid expired with both doors closed → ARMED.
- DISARMED (status_led = 0, siren_en = 0):
  - ignition = 0 and door_driver = 1 → WAIT_DOOR_CLOSE.
- WAIT_DOOR_CLOSE (status_led = 0):
  - ignition = 1 → DISARMED.
  - door_driver = 0 and door_pass = 0 → WAIT_ARM, start with T_ARM.
- WAIT_ARM (status_led = 0):
  - ignition = 1 → DISARMED.
  - Any door opens → WAIT_DOOR_CLOSE (the countdown is abandoned).
  - Valid expired → ARMED.
- Reprogram:
  - On the edge with reprogram = 1, the parameter indexed by time_param_sel takes time_value.
  - State forced to ARMED; siren_en = 0; status_led = 1; no start pulse.
  - reprogram has priority over all FSM transitions in that cycle.
  - A start pulse already launched in the same cycle is harmless, because the ARMED state ignores expired.
- Parameter reads:
  - Combinational from the parameter registers.
  - A reprogram and a start of the same parameter cannot coincide, since reprogram overrides the transition.
- Width rules: all intervals are 4-bit unsigned (0..15 s); no arithmetic is performed in this block.
- A one_hz_enable arriving in any state other than TRIGGERED is ignored.

Test Plan:
- Reset, then open the driver door with ignition = 0 → start_timer pulses once with value = 8 and state = 1. Hold expired = 0 for 80 cycles, then assert expired = 1 → state = 2, start_timer pulses with value = 10, siren_en = 1.
- In TRIGGERED, raise ignition before expiry → state = 3, siren_en = 0, status_led = 0, no further start pulses.
- Drive expired = 1 during the start-pulse edge only → state unchanged (guard). Keep expired = 1 one edge later → transition taken.
- SIREN expiry with door_pass = 1 → second start pulse with value = 10, state stays 2. Expiry with both doors closed → state = 0, siren_en = 0.
- Run DISARMED → ignition off → driver door open then close → start pulse with value = 6. Reopen the door mid-count → state = 4. Close again → new value = 6 pulse. Expire → state = 0.
- Pulse reprogram with sel = 2 and time_value = 3, then open the passenger door → value = 3. Assert reset mid-SIREN → siren_en = 0, status_led = 1, state = 0, and PASS reverts to 15.
